// File: rtl/mem_access_master.sv
// Memory access master. Turns byte, halfword and word load/store requests into
// transactions on a word-only memory, using read-modify-write for sub-word stores.
module mem_access_master #(
  parameter int ADDR_W     = 10,
  parameter bit BIG_ENDIAN = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic              resp_err,
  output logic [31:0]       resp_rdata,
  output logic [ADDR_W-1:0] MemAddr,
  output logic [31:0]       MemWriteData,
  output logic              MemRead,
  output logic              MemWrite,
  input  logic [31:0]       MemReadData
);

  typedef enum logic [2:0] {IDLE, RD, RDATA, WR, RESP} state_t;

  state_t      state;
  logic        lat_write;
  logic        lat_signed;
  logic [1:0]  lat_size;
  logic [1:0]  lat_off;
  logic [31:0] lat_wdata;

  logic        req_err;
  logic [1:0]  lane;
  logic        half_sel;
  logic [4:0]  lane_shift;
  logic [4:0]  half_shift;
  logic [7:0]  byte_raw;
  logic [15:0] half_raw;
  logic [31:0] load_val;
  logic [31:0] merge_val;

  // Anything that cannot map onto one aligned word inside the memory is rejected up front.
  always_comb begin
    req_err = 1'b0;
    if (req_size == 2'b11)
      req_err = 1'b1;
    if (req_size == 2'b01 && req_addr[0])
      req_err = 1'b1;
    if (req_size == 2'b10 && req_addr[1:0] != 2'b00)
      req_err = 1'b1;
    if ((req_addr >> (ADDR_W + 2)) != 32'd0)
      req_err = 1'b1;
  end

  always_comb begin
    lane       = BIG_ENDIAN ? (2'd3 - lat_off) : lat_off;
    half_sel   = lat_off[1] ^ BIG_ENDIAN;
    lane_shift = {lane, 3'b000};
    half_shift = {half_sel, 4'b0000};
    byte_raw   = 8'(MemReadData >> lane_shift);
    half_raw   = 16'(MemReadData >> half_shift);
    load_val   = MemReadData;
    merge_val  = lat_wdata;
    case (lat_size)
      2'b00: begin
        load_val  = lat_signed ? {{24{byte_raw[7]}}, byte_raw} : {24'd0, byte_raw};
        merge_val = (MemReadData & ~(32'h0000_00FF << lane_shift)) |
                    ({24'd0, lat_wdata[7:0]} << lane_shift);
      end
      2'b01: begin
        load_val  = lat_signed ? {{16{half_raw[15]}}, half_raw} : {16'd0, half_raw};
        merge_val = (MemReadData & ~(32'h0000_FFFF << half_shift)) |
                    ({16'd0, lat_wdata[15:0]} << half_shift);
      end
      default: begin
        load_val  = MemReadData;
        merge_val = lat_wdata;
      end
    endcase
  end

  // Strobes are registered copies of the next state so they never glitch or overlap.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      req_ready    <= 1'b0;
      resp_valid   <= 1'b0;
      resp_err     <= 1'b0;
      resp_rdata   <= 32'd0;
      MemAddr      <= '0;
      MemWriteData <= 32'd0;
      MemRead      <= 1'b0;
      MemWrite     <= 1'b0;
      lat_write    <= 1'b0;
      lat_signed   <= 1'b0;
      lat_size     <= 2'b00;
      lat_off      <= 2'b00;
      lat_wdata    <= 32'd0;
    end else begin
      resp_valid <= 1'b0;
      MemRead    <= 1'b0;
      MemWrite   <= 1'b0;
      case (state)
        IDLE: begin
          req_ready <= 1'b1;
          if (req_ready && req_valid) begin
            req_ready  <= 1'b0;
            lat_write  <= req_write;
            lat_signed <= req_signed;
            lat_size   <= req_size;
            lat_off    <= req_addr[1:0];
            lat_wdata  <= req_wdata;
            resp_err   <= req_err;
            resp_rdata <= 32'd0;
            MemAddr    <= req_addr[ADDR_W+1:2];
            if (req_err) begin
              state      <= RESP;
              resp_valid <= 1'b1;
            end else if (req_write && req_size == 2'b10) begin
              state        <= WR;
              MemWrite     <= 1'b1;
              MemWriteData <= req_wdata;
            end else begin
              state   <= RD;
              MemRead <= 1'b1;
            end
          end
        end
        RD: state <= RDATA;
        RDATA: begin
          if (lat_write) begin
            MemWriteData <= merge_val;
            MemWrite     <= 1'b1;
            state        <= WR;
          end else begin
            resp_rdata <= load_val;
            resp_valid <= 1'b1;
            state      <= RESP;
          end
        end
        WR: begin
          resp_valid <= 1'b1;
          state      <= RESP;
        end
        RESP: begin
          req_ready <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_master.sv
// Directed bench for mem_access_master with a behavioural 1024x32 memory
// (registered read) and hand-computed expected values.
module tb_mem_access_master;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_err;
  logic [31:0] resp_rdata;
  logic [9:0]  MemAddr;
  logic [31:0] MemWriteData;
  logic        MemRead;
  logic        MemWrite;
  logic [31:0] MemReadData;

  logic [31:0] mem [0:1023];

  int checks   = 0;
  int failures = 0;

  logic [31:0] lastWdata;
  logic [31:0] lastStrobeAddr;

  mem_access_master #(.ADDR_W(10), .BIG_ENDIAN(1'b0)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_err(resp_err),
    .resp_rdata(resp_rdata), .MemAddr(MemAddr), .MemWriteData(MemWriteData),
    .MemRead(MemRead), .MemWrite(MemWrite), .MemReadData(MemReadData)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (MemWrite)
      mem[MemAddr] <= MemWriteData;
    if (MemRead)
      MemReadData <= mem[MemAddr];
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  always @(negedge clk) begin
    if (!reset && MemRead && MemWrite)
      checkOutput("strobe_overlap", 32'd1, 32'd0);
  end

  task automatic waitReady(input string tag);
    for (int i = 0; i < 50 && !req_ready; i++)
      @(negedge clk);
    if (!req_ready)
      checkOutput({tag, "_ready_timeout"}, 32'd0, 32'd1);
  endtask

  // Issues one request and checks latency, response and memory strobe activity.
  task automatic applyStimulus(input string tag, input logic wr, input logic [1:0] sz,
                               input logic sgn, input logic [31:0] addr, input logic [31:0] wdata,
                               input int expLat, input logic [31:0] expData, input logic expErr,
                               input int expReads, input int expWrites);
    int lat = 0;
    int reads = 0;
    int writes = 0;
    logic [31:0] data = 32'hxxxx_xxxx;
    logic err = 1'bx;
    waitReady(tag);
    req_valid  = 1'b1;
    req_write  = wr;
    req_size   = sz;
    req_signed = sgn;
    req_addr   = addr;
    req_wdata  = wdata;
    @(posedge clk);
    #1 req_valid = 1'b0;
    for (int c = 1; c <= 20 && lat == 0; c++) begin
      @(negedge clk);
      if (MemRead) begin
        reads++;
        lastStrobeAddr = 32'(MemAddr);
      end
      if (MemWrite) begin
        writes++;
        lastWdata      = MemWriteData;
        lastStrobeAddr = 32'(MemAddr);
      end
      if (resp_valid) begin
        lat  = c;
        data = resp_rdata;
        err  = resp_err;
      end
    end
    checkOutput({tag, "_latency"}, 32'(lat), 32'(expLat));
    checkOutput({tag, "_rdata"}, data, expData);
    checkOutput({tag, "_err"}, 32'(err), 32'(expErr));
    checkOutput({tag, "_reads"}, 32'(reads), 32'(expReads));
    checkOutput({tag, "_writes"}, 32'(writes), 32'(expWrites));
    @(negedge clk);
    checkOutput({tag, "_pulse_end"}, 32'(resp_valid), 32'd0);
  endtask

  logic [31:0] expStream [0:5];
  int respCount;
  int issued;
  int writesSeen;

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00;
    req_signed = 1'b0; req_addr = 32'd0; req_wdata = 32'd0;
    lastWdata = 32'd0; lastStrobeAddr = 32'd0;
    repeat (3) @(negedge clk);
    checkOutput("rst_ready", 32'(req_ready), 32'd0);
    checkOutput("rst_resp_valid", 32'(resp_valid), 32'd0);
    checkOutput("rst_resp_err", 32'(resp_err), 32'd0);
    checkOutput("rst_strobes", {30'd0, MemRead, MemWrite}, 32'd0);
    checkOutput("rst_rdata", resp_rdata, 32'd0);
    checkOutput("rst_memaddr", 32'(MemAddr), 32'd0);
    checkOutput("rst_memwdata", MemWriteData, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("rst_release_ready", 32'(req_ready), 32'd1);

    $display("[TB] word store / load");
    applyStimulus("sw_100", 1'b1, 2'b10, 1'b0, 32'h100, 32'h1122_3344, 2, 32'd0, 1'b0, 0, 1);
    checkOutput("sw_100_memaddr", lastStrobeAddr, 32'h040);
    checkOutput("sw_100_wdata", lastWdata, 32'h1122_3344);
    applyStimulus("lw_100", 1'b0, 2'b10, 1'b0, 32'h100, 32'd0, 3, 32'h1122_3344, 1'b0, 1, 0);

    $display("[TB] sub-word store / loads");
    applyStimulus("sb_102", 1'b1, 2'b00, 1'b0, 32'h102, 32'h0000_00AB, 4, 32'd0, 1'b0, 1, 1);
    checkOutput("sb_102_wdata", lastWdata, 32'h11AB_3344);
    applyStimulus("lb_102_s", 1'b0, 2'b00, 1'b1, 32'h102, 32'd0, 3, 32'hFFFF_FFAB, 1'b0, 1, 0);
    applyStimulus("lb_102_u", 1'b0, 2'b00, 1'b0, 32'h102, 32'd0, 3, 32'h0000_00AB, 1'b0, 1, 0);
    applyStimulus("lh_102_s", 1'b0, 2'b01, 1'b1, 32'h102, 32'd0, 3, 32'h0000_11AB, 1'b0, 1, 0);
    applyStimulus("lh_100_u", 1'b0, 2'b01, 1'b0, 32'h100, 32'd0, 3, 32'h0000_3344, 1'b0, 1, 0);
    applyStimulus("sh_100", 1'b1, 2'b01, 1'b0, 32'h100, 32'h1234_BEEF, 4, 32'd0, 1'b0, 1, 1);
    checkOutput("sh_100_wdata", lastWdata, 32'h11AB_BEEF);
    applyStimulus("lh_100_s", 1'b0, 2'b01, 1'b1, 32'h100, 32'd0, 3, 32'hFFFF_BEEF, 1'b0, 1, 0);
    applyStimulus("lb_103_s", 1'b0, 2'b00, 1'b1, 32'h103, 32'd0, 3, 32'h0000_0011, 1'b0, 1, 0);

    $display("[TB] range boundary and errors");
    applyStimulus("sw_ffc", 1'b1, 2'b10, 1'b0, 32'hFFC, 32'hA5A5_0FF0, 2, 32'd0, 1'b0, 0, 1);
    checkOutput("sw_ffc_memaddr", lastStrobeAddr, 32'h3FF);
    applyStimulus("lw_ffc", 1'b0, 2'b10, 1'b0, 32'hFFC, 32'd0, 3, 32'hA5A5_0FF0, 1'b0, 1, 0);
    applyStimulus("err_lh_101", 1'b0, 2'b01, 1'b0, 32'h101, 32'd0, 1, 32'd0, 1'b1, 0, 0);
    applyStimulus("err_lw_102", 1'b0, 2'b10, 1'b0, 32'h102, 32'd0, 1, 32'd0, 1'b1, 0, 0);
    applyStimulus("err_size3", 1'b0, 2'b11, 1'b0, 32'h100, 32'd0, 1, 32'd0, 1'b1, 0, 0);
    applyStimulus("err_lw_1000", 1'b0, 2'b10, 1'b0, 32'h1000, 32'd0, 1, 32'd0, 1'b1, 0, 0);
    applyStimulus("err_sw_1000", 1'b1, 2'b10, 1'b0, 32'h1000, 32'hDEAD_BEEF, 1, 32'd0, 1'b1, 0, 0);

    $display("[TB] reset during read-modify-write");
    applyStimulus("sw_104", 1'b1, 2'b10, 1'b0, 32'h104, 32'hCAFE_F00D, 2, 32'd0, 1'b0, 0, 1);
    waitReady("sb_abort");
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'b00; req_signed = 1'b0;
    req_addr = 32'h105; req_wdata = 32'h0000_0077;
    @(posedge clk);
    #1 req_valid = 1'b0;
    writesSeen = 0;
    respCount  = 0;
    @(negedge clk);
    checkOutput("sb_abort_rd", 32'(MemRead), 32'd1);
    @(negedge clk);
    reset = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (MemWrite) writesSeen++;
      if (resp_valid) respCount++;
    end
    reset = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (c == 0)
        checkOutput("sb_abort_ready", 32'(req_ready), 32'd1);
      if (MemWrite) writesSeen++;
      if (resp_valid) respCount++;
    end
    checkOutput("sb_abort_writes", 32'(writesSeen), 32'd0);
    checkOutput("sb_abort_resp", 32'(respCount), 32'd0);
    checkOutput("sb_abort_mem", mem[10'h041], 32'hCAFE_F00D);
    applyStimulus("lw_104", 1'b0, 2'b10, 1'b0, 32'h104, 32'd0, 3, 32'hCAFE_F00D, 1'b0, 1, 0);

    $display("[TB] back-to-back with req_valid held high");
    applyStimulus("sw_208", 1'b1, 2'b10, 1'b0, 32'h208, 32'h55AA_55AA, 2, 32'd0, 1'b0, 0, 1);
    expStream[0] = 32'd0; expStream[1] = 32'h0102_0304;
    expStream[2] = 32'd0; expStream[3] = 32'hF0E0_D0C0;
    expStream[4] = 32'd0; expStream[5] = 32'h7777_8888;
    waitReady("stream");
    issued    = 0;
    respCount = 0;
    req_valid = 1'b1;
    for (int c = 0; c < 200 && respCount < 6; c++) begin
      if (req_ready && issued < 6) begin
        req_write = (issued % 2 == 0);
        req_size  = 2'b10;
        req_addr  = (issued < 2 || issued >= 4) ? 32'h200 : 32'h204;
        req_wdata = (issued == 0) ? 32'h0102_0304 :
                    (issued == 2) ? 32'hF0E0_D0C0 : 32'h7777_8888;
        issued++;
      end else begin
        req_write = 1'b1;
        req_size  = 2'b10;
        req_addr  = 32'h208;
        req_wdata = 32'hDEAD_DEAD;
      end
      @(negedge clk);
      if (resp_valid) begin
        checkOutput($sformatf("stream_rdata%0d", respCount), resp_rdata, expStream[respCount]);
        checkOutput($sformatf("stream_err%0d", respCount), 32'(resp_err), 32'd0);
        respCount++;
      end
    end
    req_valid = 1'b0;
    checkOutput("stream_issued", 32'(issued), 32'd6);
    checkOutput("stream_resp_count", 32'(respCount), 32'd6);
    repeat (6) begin
      @(negedge clk);
      if (resp_valid) respCount++;
    end
    checkOutput("stream_no_extra_resp", 32'(respCount), 32'd6);
    applyStimulus("lw_208", 1'b0, 2'b10, 1'b0, 32'h208, 32'd0, 3, 32'h55AA_55AA, 1'b0, 1, 0);
    applyStimulus("lw_204", 1'b0, 2'b10, 1'b0, 32'h204, 32'd0, 3, 32'hF0E0_D0C0, 1'b0, 1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout observed=%0t expected=finish", $time);
    $fatal(1, "[TB] simulation time limit reached");
  end

endmodule
